// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: merges stage stall requests, converts MEM exceptions
// into a one-cycle flush with a handler address, masks exceptions during a
// short recovery window, and keeps a stall watchdog and flush counter.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_BASE       = 32'h0000_0000,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned STALL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic        masked_exc,
  output logic [15:0] exc_count
);

  // state    | meaning
  // ST_IDLE   | normal operation, exceptions are accepted
  // ST_RECOVER| post-flush window, exceptions are ignored and recorded
  typedef enum logic {ST_IDLE, ST_RECOVER} state_t;

  localparam logic [3:0]  REC_LOAD = 4'(RECOVER_CYCLES - 1);
  localparam logic [15:0] WD_TRIP  = 16'(STALL_LIMIT - 1);

  state_t      state;
  logic [3:0]  rec_cnt;
  logic [15:0] wd_cnt;
  logic        exc_pending;
  logic        accept;
  logic [5:0]  stall_req;

  assign exc_pending = |excepttype_i;
  assign accept      = !rst && (state == ST_IDLE) && exc_pending;

  // Combinational stall/flush/new_pc; flush overrides stall, reset forces all low
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)      stall_req = 6'b011111;
    else if (stallreq_ex)  stall_req = 6'b001111;
    else if (stallreq_id)  stall_req = 6'b000111;

    stall  = (rst || accept) ? 6'b000000 : stall_req;
    flush  = accept;
    new_pc = 32'h0000_0000;
    if (accept) begin
      case (excepttype_i)
        32'h0000_0001: new_pc = EXC_BASE + 32'h20;
        32'h0000_0008,
        32'h0000_000a,
        32'h0000_000c,
        32'h0000_000d: new_pc = EXC_BASE + 32'h40;
        32'h0000_000e: new_pc = cp0_epc_i;
        default:       new_pc = EXC_BASE + 32'h40;
      endcase
    end
  end

  // Exception FSM with recovery counter, flush counter and masked-exception flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rec_cnt    <= 4'd0;
      exc_count  <= 16'd0;
      masked_exc <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exc_pending) begin
            state     <= ST_RECOVER;
            rec_cnt   <= REC_LOAD;
            exc_count <= exc_count + 16'd1;
          end
        end
        ST_RECOVER: begin
          if (exc_pending) masked_exc <= 1'b1;
          if (rec_cnt == 4'd0) state <= ST_IDLE;
          else                 rec_cnt <= rec_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall watchdog: saturating run-length counter of stalled cycles, sticky trip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt        <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      if (flush || (stall == 6'b000000)) wd_cnt <= 16'd0;
      else if (wd_cnt != 16'hFFFF)       wd_cnt <= wd_cnt + 16'd1;
      if ((stall != 6'b000000) && (wd_cnt == WD_TRIP)) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int RC = 2;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst, sid, sex, smem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush, stall_timeout, masked_exc;
  logic [31:0] new_pc;
  logic [15:0] exc_count;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int          cyc;
  int          last_flush;
  int          run;
  logic        m_timeout, m_masked;
  logic [15:0] m_count;
  logic [5:0]  exp_stall;
  logic        exp_flush;
  logic [31:0] exp_pc;

  pipeline_ctrl #(.EXC_BASE(BASE), .RECOVER_CYCLES(RC), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .excepttype_i(exc), .cp0_epc_i(epc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .masked_exc(masked_exc), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vector_of(input logic [31:0] code, input logic [31:0] e);
    if (code == 32'h1) return BASE + 32'h20;
    if (code == 32'he) return e;
    return BASE + 32'h40;
  endfunction

  // Apply inputs, compute expected combinational outputs, wait to mid-cycle
  task automatic drive(input logic r, input logic i, input logic x, input logic m,
                       input logic [31:0] code, input logic [31:0] e);
    int held;
    logic acc;
    rst = r; sid = i; sex = x; smem = m; exc = code; epc = e;
    acc  = !r && (code != 0) && (cyc - last_flush > RC);
    held = m ? 5 : (x ? 4 : (i ? 3 : 0));
    exp_flush = acc;
    exp_stall = (r || acc) ? 6'd0 : 6'((1 << held) - 1);
    exp_pc    = acc ? vector_of(code, e) : 32'h0;
    #4;
  endtask

  // Clock edge and model update
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      last_flush = -100; run = 0; m_timeout = 0; m_masked = 0; m_count = 0;
    end else begin
      if (exp_flush) begin
        last_flush = cyc; m_count = m_count + 16'd1;
      end else if (exc != 0) begin
        m_masked = 1;
      end
      if (exp_stall != 0) begin
        run++;
        if (run >= SL) m_timeout = 1;
      end else begin
        run = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 32'h1, 32'h0);
    checks++; if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin fails++;
      $display("FAIL reset_force: stall=%b flush=%b pc=%h want 0/0/0", stall, flush, new_pc); end
    tick();
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin fails++;
      $display("FAIL reset_idle: stall=%b flush=%b pc=%h want 0/0/0", stall, flush, new_pc); end
    checks++; if (exc_count !== 16'd0 || stall_timeout !== 1'b0 || masked_exc !== 1'b0) begin fails++;
      $display("FAIL reset_regs: cnt=%0d to=%b mk=%b want 0/0/0", exc_count, stall_timeout, masked_exc); end
    tick();
  endtask

  task automatic test_stall_priority();
    logic [5:0] want [4] = '{6'b000111, 6'b001111, 6'b011111, 6'b000000};
    logic [2:0] req  [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    for (int k = 0; k < 4; k++) begin
      drive(0, req[k][0], req[k][1], req[k][2], 32'h0, 32'h0);
      checks++; if (stall !== want[k] || stall !== exp_stall) begin fails++;
        $display("FAIL stall_prio[%0d]: got %b want %b", k, stall, want[k]); end
      tick();
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      tick();
    end
  endtask

  task automatic test_exc_vectors();
    logic [31:0] codes [3] = '{32'h1, 32'h8, 32'he};
    logic [31:0] pcs   [3] = '{32'h20, 32'h40, 32'h80000104};
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, codes[k], 32'h80000104);
      checks++; if (flush !== 1'b1 || new_pc !== pcs[k]) begin fails++;
        $display("FAIL exc_vec[%0d]: flush=%b pc=%h want 1/%h", k, flush, new_pc, pcs[k]); end
      tick();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin fails++;
        $display("FAIL exc_onecycle[%0d]: flush=%b pc=%h want 0/0", k, flush, new_pc); end
      tick();
      idle_ticks(2);
    end
    checks++; if (exc_count !== 16'd3 || exc_count !== m_count) begin fails++;
      $display("FAIL exc_count3: got %0d want 3", exc_count); end
  endtask

  task automatic test_flush_vs_stall();
    drive(0, 0, 1, 0, 32'hc, 32'h0);
    checks++; if (stall !== 6'd0 || flush !== 1'b1 || new_pc !== 32'h40) begin fails++;
      $display("FAIL flush_wins: stall=%b flush=%b pc=%h want 0/1/40", stall, flush, new_pc); end
    tick();
    drive(0, 0, 1, 0, 32'h1, 32'h0);
    checks++; if (flush !== 1'b0 || stall !== 6'b001111) begin fails++;
      $display("FAIL masked_cycle: flush=%b stall=%b want 0/001111", flush, stall); end
    tick();
    checks++; if (masked_exc !== 1'b1) begin fails++;
      $display("FAIL masked_flag: got %b want 1", masked_exc); end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h1, 32'h0);
    checks++; if (flush !== 1'b1 || new_pc !== 32'h20) begin fails++;
      $display("FAIL after_recover: flush=%b pc=%h want 1/20", flush, new_pc); end
    tick();
    idle_ticks(3);
  endtask

  task automatic test_watchdog();
    drive(1, 0, 0, 0, 32'h0, 32'h0); tick();
    for (int k = 0; k < SL - 1; k++) begin drive(0, 0, 0, 1, 32'h0, 32'h0); tick(); end
    idle_ticks(1);
    checks++; if (stall_timeout !== 1'b0) begin fails++;
      $display("FAIL wd_short: got %b want 0", stall_timeout); end
    for (int k = 0; k < SL; k++) begin
      drive(0, 0, 0, 1, 32'h0, 32'h0);
      if (k == SL - 1) begin
        checks++; if (stall_timeout !== 1'b0) begin fails++;
          $display("FAIL wd_early: got %b want 0", stall_timeout); end
      end
      tick();
    end
    checks++; if (stall_timeout !== 1'b1) begin fails++;
      $display("FAIL wd_trip: got %b want 1", stall_timeout); end
    idle_ticks(3);
    checks++; if (stall_timeout !== 1'b1) begin fails++;
      $display("FAIL wd_sticky: got %b want 1", stall_timeout); end
  endtask

  task automatic test_reset_mid_recover();
    drive(0, 0, 0, 0, 32'h1, 32'h0); tick();
    drive(1, 1, 0, 1, 32'h8, 32'h0);
    checks++; if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin fails++;
      $display("FAIL rst_recover: stall=%b flush=%b pc=%h want 0/0/0", stall, flush, new_pc); end
    tick();
    drive(0, 0, 0, 0, 32'h8, 32'h0);
    checks++; if (flush !== 1'b1 || new_pc !== 32'h40) begin fails++;
      $display("FAIL post_rst_exc: flush=%b pc=%h want 1/40", flush, new_pc); end
    tick();
    checks++; if (exc_count !== 16'd1 || masked_exc !== 1'b0 || stall_timeout !== 1'b0) begin fails++;
      $display("FAIL post_rst_regs: cnt=%0d mk=%b to=%b want 1/0/0", exc_count, masked_exc, stall_timeout); end
    idle_ticks(3);
  endtask

  task automatic test_random();
    logic [31:0] pool [7] = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h33};
    logic [31:0] code;
    logic r;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 59) == 0);
      code = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 6)] : 32'h0;
      drive(r, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), code, $urandom);
      checks++; if (stall !== exp_stall || flush !== exp_flush || new_pc !== exp_pc) begin fails++;
        $display("FAIL rand_comb[%0d]: stall=%b flush=%b pc=%h want %b/%b/%h",
                 k, stall, flush, new_pc, exp_stall, exp_flush, exp_pc); end
      tick();
      checks++; if (exc_count !== m_count || masked_exc !== m_masked || stall_timeout !== m_timeout) begin fails++;
        $display("FAIL rand_regs[%0d]: cnt=%0d mk=%b to=%b want %0d/%b/%b",
                 k, exc_count, masked_exc, stall_timeout, m_count, m_masked, m_timeout); end
    end
  endtask

  initial begin
    cyc = 0; last_flush = -100; run = 0; m_timeout = 0; m_masked = 0; m_count = 0;
    test_reset();
    test_stall_priority();
    test_exc_vectors();
    test_flush_vs_stall();
    test_watchdog();
    test_reset_mid_recover();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
